conv_win_fetch: RTL and testbench
=================================

Name: conv_win_fetch

Overview:
- Parametrised window-fetch engine for conv layers; next generation of the fixed 6x6 / 4-channel Conv1 read sequencer.
- Walks a runtime-configured output grid and channel-group count.
- Issues four interleaved SRAM group-A read addresses per window and reorders the returned banks into top-left/top-right/bottom-left/bottom-right order.
- Delivers windows downstream over a valid/ready handshake with full backpressure support; sits between SRAM group A and the MAC array.

Parameters:
- CH_NUM, 4, channels per SRAM word.
- ACT_PER_ADDR, 4, activations per channel per word (2x2 pixel block).
- BW_PER_ACT, 8, bits per activation.
- ADDR_W, 10, SRAM address width.
- DIM_W, 6, width of grid/count config fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  begin job; config sampled this cycle.
- cfg_out_w_m1  in  DIM_W  output columns minus 1.
- cfg_out_h_m1  in  DIM_W  output rows minus 1.
- cfg_cg_m1  in  DIM_W  channel groups minus 1.
- cfg_row_stride  in  ADDR_W  bank-address step per block-row pair.
- cfg_cg_stride  in  ADDR_W  bank-address step per channel group.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- sram_raddr_a0..a3  out  ADDR_W each  bank read addresses (registered).
- sram_rdata_a0..a3  in  DW each  bank read data; DW = CH_NUM*ACT_PER_ADDR*BW_PER_ACT.
- out_valid  out  1  window available.
- out_ready  in  1  consumer accepts.
- out_tl, out_tr, out_bl, out_br  out  DW each  reordered window blocks.
- out_row, out_col, out_cg  out  DIM_W each  window coordinates.
- out_last  out  1  final window of job.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: busy=0, done=0, out_valid=0, out_last=0, all raddr=0, counters=0, FIFO empty. Reset mid-job aborts it; no done pulse is produced.
- States: IDLE -> RUN on start (cfg latched). RUN -> DRAIN after the last window is issued. DRAIN -> IDLE when the last window pops. done=1 for exactly one cycle, the cycle after that pop; busy drops on the same cycle. start while busy is ignored.
- Loop order: cg innermost, then col, then row. The last window is (row=h_m1, col=w_m1, cg=cg_m1).
- Block (br, bc) is in bank b = {br[0], bc[0]} (a0=00, a1=01, a2=10, a3=11). Address = cg*cg_stride + (br>>1)*row_stride + (bc>>1), computed modulo 2^ADDR_W.
- The window at (r, c) covers blocks r..r+1 by c..c+1. Each bank gets the unique covering block with matching parity.
- SRAM latency is 1: rdata is valid the cycle after raddr is presented.
- Reorder on capture, with sel = {r[0], c[0]}:
  - tl = bank sel
  - tr = bank sel^01
  - bl = bank sel^10
  - br = bank sel^11
  - Coordinates and last travel with the data.
- Output is a 2-entry FIFO; the head drives the out_* ports.
- Issue rule: a new read issues in a cycle iff RUN and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready. Sustained throughput is 1 window/cycle with out_ready high.
- When not issuing, raddr holds its value. SRAM re-reads are harmless because capture happens only for issued reads.
- Simultaneous push and pop keeps the count unchanged. The FIFO never overflows, by construction of the issue rule.
- out_* are stable while out_valid=1 and out_ready=0.
- First out_valid is 2 cycles after the start cycle (cycle 1: issue, cycle 2: captured).

Test Plan:
- Config w_m1=h_m1=5, cg_m1=0, row_stride=4; start, out_ready=1 -> 36 windows on consecutive cycles starting 2 cycles after start. Window (0,1): raddr a0=1, a1=0, a2=1, a3=0; out_tl=rdata_a1, out_tr=rdata_a0. done pulses once, 1 cycle after window (5,5) pops.
- Window (1,1), row_stride=4 -> raddr a0=5, a1=4, a2=1, a3=0; out_tl=rdata_a3, out_br=rdata_a0.
- cg_m1=2, cg_stride=32, 2x2 grid -> 12 windows in order (0,0,0),(0,0,1),(0,0,2),(0,1,0)...; addresses offset by 0/32/64; out_last only on (1,1,2).
- Random out_ready (about 50%) on 6x6 -> identical window sequence to the ready=1 run; no drops or duplicates; outputs held stable while stalled.
- Reset asserted mid-RUN, then start again with w_m1=h_m1=0 -> outputs cleared; next job emits exactly 1 window (0,0,0) with out_last=1, then done.
- start pulsed while busy with a different cfg -> ignored; the current job completes with its original geometry.

Source files
------------

// File: rtl/conv_win_fetch.sv
// conv_win_fetch: window-fetch engine sitting between SRAM group A and the MAC array.
//
// A job walks an output grid of (cfg_out_h_m1+1) x (cfg_out_w_m1+1) windows. Each
// window position is visited once per channel group (cfg_cg_m1+1 groups). The loop
// order is cg innermost, then column, then row. Every window covers a 2x2 set of
// pixel blocks. The blocks sit in four banks selected by {block_row[0], block_col[0]}.
// One read is issued to each bank per window. The returned words are then reordered
// into top-left / top-right / bottom-left / bottom-right order.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start               begin a job; the cfg_* inputs are sampled in this cycle (IDLE only)
//   cfg_out_w_m1/h_m1   output columns/rows minus 1
//   cfg_cg_m1           channel groups minus 1
//   cfg_row_stride      bank-address step per block-row pair
//   cfg_cg_stride       bank-address step per channel group
//   busy, done          job in progress / one-cycle pulse after the last window pops
//   sram_raddr_a0..a3   registered bank read addresses
//   sram_rdata_a0..a3   bank read data, valid one cycle after the address
//   out_valid/out_ready downstream handshake
//   out_tl/tr/bl/br     reordered window blocks
//   out_row/col/cg      window coordinates
//   out_last            final window of the job
module conv_win_fetch #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 8,
    parameter int ADDR_W       = 10,
    parameter int DIM_W        = 6,
    localparam int DW          = CH_NUM * ACT_PER_ADDR * BW_PER_ACT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_out_w_m1,
    input  logic [DIM_W-1:0]  cfg_out_h_m1,
    input  logic [DIM_W-1:0]  cfg_cg_m1,
    input  logic [ADDR_W-1:0] cfg_row_stride,
    input  logic [ADDR_W-1:0] cfg_cg_stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_raddr_a0,
    output logic [ADDR_W-1:0] sram_raddr_a1,
    output logic [ADDR_W-1:0] sram_raddr_a2,
    output logic [ADDR_W-1:0] sram_raddr_a3,
    input  logic [DW-1:0]     sram_rdata_a0,
    input  logic [DW-1:0]     sram_rdata_a1,
    input  logic [DW-1:0]     sram_rdata_a2,
    input  logic [DW-1:0]     sram_rdata_a3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_tl,
    output logic [DW-1:0]     out_tr,
    output logic [DW-1:0]     out_bl,
    output logic [DW-1:0]     out_br,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic [DIM_W-1:0]  out_cg,
    output logic              out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DW-1:0]    tl;
        logic [DW-1:0]    tr;
        logic [DW-1:0]    bl;
        logic [DW-1:0]    br;
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
        logic [DIM_W-1:0] cg;
        logic             last;
    } win_t;

    // Bank address for the covering block of parity (pr, pc) in window (r, c), group g.
    // Each block-row index is either r or r+1. The first choice is the one whose parity
    // matches pr, so its half index is (r>>1), plus one only when r is odd and pr is
    // even. Columns follow the same rule.
    function automatic logic [ADDR_W-1:0] bank_addr(
        input logic [DIM_W-1:0]  r,
        input logic [DIM_W-1:0]  c,
        input logic [DIM_W-1:0]  g,
        input logic              pr,
        input logic              pc,
        input logic [ADDR_W-1:0] row_stride,
        input logic [ADDR_W-1:0] cg_stride
    );
        logic [ADDR_W-1:0] half_r;
        logic [ADDR_W-1:0] half_c;
        half_r = ADDR_W'(r >> 1) + ADDR_W'(r[0] & ~pr);
        half_c = ADDR_W'(c >> 1) + ADDR_W'(c[0] & ~pc);
        return ADDR_W'(g) * cg_stride + half_r * row_stride + half_c;
    endfunction

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  w_m1_q, w_m1_d, h_m1_q, h_m1_d, cg_m1_q, cg_m1_d;
    logic [ADDR_W-1:0] row_stride_q, row_stride_d, cg_stride_q, cg_stride_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, cg_q, cg_d;
    logic [ADDR_W-1:0] raddr_q [4];
    logic [ADDR_W-1:0] raddr_d [4];
    logic              infl_q, infl_d;
    logic [DIM_W-1:0]  infl_row_q, infl_row_d, infl_col_q, infl_col_d, infl_cg_q, infl_cg_d;
    logic              infl_last_q, infl_last_d;
    win_t              fifo_q [2];
    win_t              fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;

    logic [DW-1:0]     bank_rd [4];
    logic [1:0]        sel;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              last_win;
    win_t              head;
    win_t              cap;

    assign bank_rd[0] = sram_rdata_a0;
    assign bank_rd[1] = sram_rdata_a1;
    assign bank_rd[2] = sram_rdata_a2;
    assign bank_rd[3] = sram_rdata_a3;

    assign head      = fifo_q[rd_ptr_q];
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;

    // Slots already owed to the FIFO once this cycle's pop has left. The in-flight read
    // always lands next cycle, so keeping this below 2 means a push never overflows.
    assign occ       = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    assign issue     = (state_q == S_RUN) && (occ < 2'd2);
    assign last_win  = (row_q == h_m1_q) && (col_q == w_m1_q) && (cg_q == cg_m1_q);

    // Reorder the returned words so that position tl always holds block (r, c).
    assign sel      = {infl_row_q[0], infl_col_q[0]};
    assign cap.tl   = bank_rd[sel];
    assign cap.tr   = bank_rd[sel ^ 2'b01];
    assign cap.bl   = bank_rd[sel ^ 2'b10];
    assign cap.br   = bank_rd[sel ^ 2'b11];
    assign cap.row  = infl_row_q;
    assign cap.col  = infl_col_q;
    assign cap.cg   = infl_cg_q;
    assign cap.last = infl_last_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a
        // latch behind.
        state_d      = state_q;
        w_m1_d       = w_m1_q;
        h_m1_d       = h_m1_q;
        cg_m1_d      = cg_m1_q;
        row_stride_d = row_stride_q;
        cg_stride_d  = cg_stride_q;
        row_d        = row_q;
        col_d        = col_q;
        cg_d         = cg_q;
        raddr_d      = raddr_q;
        infl_d       = issue;
        infl_row_d   = infl_row_q;
        infl_col_d   = infl_col_q;
        infl_cg_d    = infl_cg_q;
        infl_last_d  = infl_last_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q ^ infl_q;
        rd_ptr_d     = rd_ptr_q ^ pop;
        cnt_d        = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        done_d       = (state_q == S_DRAIN) && pop && head.last;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_m1_d       = cfg_out_w_m1;
                    h_m1_d       = cfg_out_h_m1;
                    cg_m1_d      = cfg_cg_m1;
                    row_stride_d = cfg_row_stride;
                    cg_stride_d  = cfg_cg_stride;
                    row_d        = '0;
                    col_d        = '0;
                    cg_d         = '0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && last_win) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && head.last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            raddr_d[0]  = bank_addr(row_q, col_q, cg_q, 1'b0, 1'b0, row_stride_q, cg_stride_q);
            raddr_d[1]  = bank_addr(row_q, col_q, cg_q, 1'b0, 1'b1, row_stride_q, cg_stride_q);
            raddr_d[2]  = bank_addr(row_q, col_q, cg_q, 1'b1, 1'b0, row_stride_q, cg_stride_q);
            raddr_d[3]  = bank_addr(row_q, col_q, cg_q, 1'b1, 1'b1, row_stride_q, cg_stride_q);
            infl_row_d  = row_q;
            infl_col_d  = col_q;
            infl_cg_d   = cg_q;
            infl_last_d = last_win;
            if (cg_q != cg_m1_q) begin
                cg_d = cg_q + DIM_W'(1);
            end else begin
                cg_d = '0;
                if (col_q != w_m1_q) begin
                    col_d = col_q + DIM_W'(1);
                end else begin
                    col_d = '0;
                    row_d = last_win ? '0 : row_q + DIM_W'(1);
                end
            end
        end

        // A read issued last cycle has its data on the bus now; capture it.
        if (infl_q) fifo_d[wr_ptr_q] = cap;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every flop
        // samples the values from before the clock edge.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            w_m1_q       <= '0;
            h_m1_q       <= '0;
            cg_m1_q      <= '0;
            row_stride_q <= '0;
            cg_stride_q  <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cg_q         <= '0;
            raddr_q      <= '{default: '0};
            infl_q       <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_m1_q       <= w_m1_d;
            h_m1_q       <= h_m1_d;
            cg_m1_q      <= cg_m1_d;
            row_stride_q <= row_stride_d;
            cg_stride_q  <= cg_stride_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cg_q         <= cg_d;
            raddr_q      <= raddr_d;
            infl_q       <= infl_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    // NOTE: FIFO storage and in-flight metadata are deliberately left unreset. They are
    // only observed while cnt_q / infl_q mark them valid, and those are reset.
    always_ff @(posedge clk) begin
        fifo_q      <= fifo_d;
        infl_row_q  <= infl_row_d;
        infl_col_q  <= infl_col_d;
        infl_cg_q   <= infl_cg_d;
        infl_last_q <= infl_last_d;
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign sram_raddr_a0 = raddr_q[0];
    assign sram_raddr_a1 = raddr_q[1];
    assign sram_raddr_a2 = raddr_q[2];
    assign sram_raddr_a3 = raddr_q[3];
    assign out_tl        = head.tl;
    assign out_tr        = head.tr;
    assign out_bl        = head.bl;
    assign out_br        = head.br;
    assign out_row       = head.row;
    assign out_col       = head.col;
    assign out_cg        = head.cg;
    assign out_last      = out_valid & head.last;

endmodule

// File: tb/tb_conv_win_fetch.sv
// Self-checking bench for conv_win_fetch.
// Four random-filled SRAM banks answer reads one cycle after the address register
// changes. A reference model builds each job's expected window list straight from
// block geometry: for every window it finds the four covering blocks and their
// bank/address pairs, and gives tl as block (r,c), tr as (r,c+1), bl as (r+1,c) and
// br as (r+1,c+1).
module tb_conv_win_fetch;
    localparam int CH_NUM       = 4;
    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_ACT   = 8;
    localparam int ADDR_W       = 10;
    localparam int DIM_W        = 6;
    localparam int DW           = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int PW           = 1 + 4 * DW + 3 * DIM_W + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DIM_W-1:0]  cfg_out_w_m1, cfg_out_h_m1, cfg_cg_m1;
    logic [ADDR_W-1:0] cfg_row_stride, cfg_cg_stride;
    logic              busy, done;
    logic [ADDR_W-1:0] sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3;
    logic [DW-1:0]     sram_rdata_a0, sram_rdata_a1, sram_rdata_a2, sram_rdata_a3;
    logic              out_valid, out_ready, out_last;
    logic [DW-1:0]     out_tl, out_tr, out_bl, out_br;
    logic [DIM_W-1:0]  out_row, out_col, out_cg;

    logic [DW-1:0]     mem [4][1024];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0]         tl, tr, bl, br;
        int                    r, c, g;
        bit                    last;
        logic [4*ADDR_W-1:0]   addrs;
    } exp_t;

    conv_win_fetch #(
        .CH_NUM(CH_NUM), .ACT_PER_ADDR(ACT_PER_ADDR), .BW_PER_ACT(BW_PER_ACT),
        .ADDR_W(ADDR_W), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_out_w_m1(cfg_out_w_m1), .cfg_out_h_m1(cfg_out_h_m1), .cfg_cg_m1(cfg_cg_m1),
        .cfg_row_stride(cfg_row_stride), .cfg_cg_stride(cfg_cg_stride),
        .busy(busy), .done(done),
        .sram_raddr_a0(sram_raddr_a0), .sram_raddr_a1(sram_raddr_a1),
        .sram_raddr_a2(sram_raddr_a2), .sram_raddr_a3(sram_raddr_a3),
        .sram_rdata_a0(sram_rdata_a0), .sram_rdata_a1(sram_rdata_a1),
        .sram_rdata_a2(sram_rdata_a2), .sram_rdata_a3(sram_rdata_a3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tl(out_tl), .out_tr(out_tr), .out_bl(out_bl), .out_br(out_br),
        .out_row(out_row), .out_col(out_col), .out_cg(out_cg), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_rdata_a0 = mem[0][sram_raddr_a0];
    assign sram_rdata_a1 = mem[1][sram_raddr_a1];
    assign sram_rdata_a2 = mem[2][sram_raddr_a2];
    assign sram_rdata_a3 = mem[3][sram_raddr_a3];

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int blk_addr(input int br, input int bc, input int g, input int rs, input int gs);
        return (g * gs + (br / 2) * rs + bc / 2) % 1024;
    endfunction

    function automatic int blk_bank(input int br, input int bc);
        return (br % 2) * 2 + (bc % 2);
    endfunction

    function automatic logic [PW-1:0] pack_out();
        return {out_valid, out_tl, out_tr, out_bl, out_br, out_row, out_col, out_cg, out_last};
    endfunction

    function automatic logic [PW-1:0] pack_exp(input exp_t e);
        return {1'b1, e.tl, e.tr, e.bl, e.br, DIM_W'(e.r), DIM_W'(e.c), DIM_W'(e.g), e.last};
    endfunction

    // Runs one job to completion. ready_pct sets the chance of out_ready being high.
    // chk_addr checks the address bus. That check needs ready held high, so each window
    // is at the FIFO head exactly one cycle after its read. busy_t >= 0 pulses start
    // (with garbage cfg) in that cycle while the job is running.
    task automatic run_job(input int w, input int h, input int cg, input int rs, input int gs,
                           input int ready_pct, input bit chk_addr, input int busy_t);
        exp_t                expq[$];
        exp_t                e;
        int                  n, t, popped, first_t, last_pop_t, done_t, done_cnt, budget;
        bit                  held, finished;
        logic [PW-1:0]       held_val;
        logic [4*ADDR_W-1:0] prev_addr;

        for (int r = 0; r <= h; r++)
            for (int c = 0; c <= w; c++)
                for (int g = 0; g <= cg; g++) begin
                    e.r    = r;
                    e.c    = c;
                    e.g    = g;
                    e.last = (r == h) && (c == w) && (g == cg);
                    e.tl   = mem[blk_bank(r, c)][blk_addr(r, c, g, rs, gs)];
                    e.tr   = mem[blk_bank(r, c + 1)][blk_addr(r, c + 1, g, rs, gs)];
                    e.bl   = mem[blk_bank(r + 1, c)][blk_addr(r + 1, c, g, rs, gs)];
                    e.br   = mem[blk_bank(r + 1, c + 1)][blk_addr(r + 1, c + 1, g, rs, gs)];
                    e.addrs = '0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            e.addrs[blk_bank(r + dr, c + dc) * ADDR_W +: ADDR_W] =
                                ADDR_W'(blk_addr(r + dr, c + dc, g, rs, gs));
                    expq.push_back(e);
                end
        n          = expq.size();
        budget     = n * 8 + 20;
        popped     = 0;
        first_t    = -1;
        last_pop_t = -100;
        done_t     = -1;
        done_cnt   = 0;
        held       = 1'b0;
        held_val   = '0;
        prev_addr  = '0;
        finished   = 1'b0;

        @(posedge clk); #1;
        start          = 1'b1;
        cfg_out_w_m1   = DIM_W'(w);
        cfg_out_h_m1   = DIM_W'(h);
        cfg_cg_m1      = DIM_W'(cg);
        cfg_row_stride = ADDR_W'(rs);
        cfg_cg_stride  = ADDR_W'(gs);
        @(posedge clk); #1;
        // The job must run on the latched config, so scramble the inputs from here on.
        cfg_out_w_m1   = DIM_W'($urandom);
        cfg_out_h_m1   = DIM_W'($urandom);
        cfg_cg_m1      = DIM_W'($urandom);
        cfg_row_stride = ADDR_W'($urandom);
        cfg_cg_stride  = ADDR_W'($urandom);
        t = 0;
        while (!finished) begin
            out_ready = ($urandom_range(99) < ready_pct);
            start     = (t == busy_t);
            @(negedge clk);
            if (out_valid && first_t < 0) first_t = t;
            if (held) check("hold", pack_out(), held_val);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("extra_window", PW'(popped + 1), PW'(n));
                end else begin
                    e = expq.pop_front();
                    check("window", pack_out(), pack_exp(e));
                    if (chk_addr) check("raddr", PW'(prev_addr), PW'(e.addrs));
                    if (chk_addr && rs == 4 && e.g == 0 && e.r == 0 && e.c == 1) begin
                        check("raddr_0_1", PW'(prev_addr), PW'({10'd0, 10'd1, 10'd0, 10'd1}));
                        check("tl_0_1", PW'(out_tl), PW'(mem[1][0]));
                    end
                    if (chk_addr && rs == 4 && e.g == 0 && e.r == 1 && e.c == 1) begin
                        check("raddr_1_1", PW'(prev_addr), PW'({10'd0, 10'd1, 10'd4, 10'd5}));
                        check("br_1_1", PW'(out_br), PW'(mem[0][5]));
                    end
                    if (e.last) last_pop_t = t;
                    popped++;
                end
            end
            if (done) begin
                done_cnt++;
                done_t = t;
                check("busy_at_done", PW'(busy), '0);
            end
            held      = out_valid && !out_ready;
            held_val  = pack_out();
            prev_addr = {sram_raddr_a3, sram_raddr_a2, sram_raddr_a1, sram_raddr_a0};
            if (popped == n && t >= last_pop_t + 3) begin
                finished = 1'b1;
            end else if (t >= budget) begin
                check("timeout_windows", PW'(popped), PW'(n));
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                t++;
            end
        end
        start = 1'b0;
        check("first_valid_t", PW'(first_t), PW'(2));
        check("n_windows", PW'(popped), PW'(n));
        check("done_count", PW'(done_cnt), PW'(1));
        check("done_t", PW'(done_t), PW'(last_pop_t + 1));
        check("busy_end", PW'(busy), '0);
    endtask

    initial begin
        int d;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++)
                mem[b][a] = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst_n          = 1'b0;
        start          = 1'b0;
        out_ready      = 1'b0;
        cfg_out_w_m1   = '0;
        cfg_out_h_m1   = '0;
        cfg_cg_m1      = '0;
        cfg_row_stride = '0;
        cfg_cg_stride  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", PW'(busy), '0);
        check("rst_done", PW'(done), '0);
        check("rst_valid", PW'(out_valid), '0);
        check("rst_last", PW'(out_last), '0);
        check("rst_raddr", PW'({sram_raddr_a3, sram_raddr_a2, sram_raddr_a1, sram_raddr_a0}), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 6x6 grid with one channel group, full throughput.
        run_job(5, 5, 0, 4, int'($urandom_range(1023)), 100, 1'b1, -1);
        // 2x2 grid with three channel groups at cg_stride 32.
        run_job(1, 1, 2, 4, 32, 100, 1'b1, -1);
        // The same 6x6 walk under random backpressure.
        run_job(5, 5, 0, 4, 0, 50, 1'b0, -1);
        // A start pulse during a running job must be ignored.
        run_job(5, 5, 0, 4, 0, 100, 1'b1, 5);
        // Random geometries and strides; large strides exercise address wrap.
        repeat (3)
            run_job(int'($urandom_range(6)), int'($urandom_range(6)), int'($urandom_range(3)),
                    int'($urandom_range(1023)), int'($urandom_range(1023)), 50, 1'b0, -1);

        // Abort a job with reset partway through.
        @(posedge clk); #1;
        start          = 1'b1;
        cfg_out_w_m1   = DIM_W'(5);
        cfg_out_h_m1   = DIM_W'(5);
        cfg_cg_m1      = '0;
        cfg_row_stride = ADDR_W'(4);
        cfg_cg_stride  = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            out_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", PW'(busy), '0);
        check("abort_done", PW'(done), '0);
        check("abort_valid", PW'(out_valid), '0);
        check("abort_last", PW'(out_last), '0);
        check("abort_raddr", PW'({sram_raddr_a3, sram_raddr_a2, sram_raddr_a1, sram_raddr_a0}), '0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        d = 0;
        repeat (4) begin
            @(negedge clk);
            d += int'(done);
        end
        check("abort_no_done", PW'(d), '0);
        // A single-window job after the abort.
        run_job(0, 0, 0, int'($urandom_range(1023)), int'($urandom_range(1023)), 100, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
